// File: rtl/cassette_pkg.sv
// Shared cassette definitions for the MC-10 tape recorder/player.
package cassette_pkg;

  typedef enum logic {HUNT, DATA} rec_state_t;

  localparam logic [7:0]  SYNC_BYTE   = 8'h3C;
  localparam logic [7:0]  LEADER_BYTE = 8'h55;
  localparam int unsigned ADDR_W      = 25;

endpackage

// File: rtl/cassette_period.sv
// Synchronizes cassette-out, measures rising-edge periods and classifies them
// into bit pulses; also flags a gap when the period counter saturates.
module cassette_period #(
  parameter int unsigned T_MIN   = 10,
  parameter int unsigned T_SPLIT = 20,
  parameter int unsigned T_MAX   = 60
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic enable,
  input  logic cout,
  output logic bit_valid,
  output logic bit_val,
  output logic gap
);

  localparam int unsigned CW = $clog2(T_MAX + 1);
  localparam logic [CW-1:0] MIN_C   = CW'(T_MIN);
  localparam logic [CW-1:0] SPLIT_C = CW'(T_SPLIT);
  localparam logic [CW-1:0] MAX_C   = CW'(T_MAX);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise, sat;

  assign rise = sync2_q & ~prev_q;
  assign sat  = (cnt_q == MAX_C);

  // Restarting at 1 makes the counter value on an edge equal the clocks
  // elapsed since the previous accepted edge.
  always_comb begin
    cnt_d     = sat ? cnt_q : cnt_q + ONE_C;
    bit_valid = 1'b0;
    bit_val   = 1'b0;
    gap       = 1'b0;
    if (!enable) begin
      cnt_d = MAX_C;
    end else if (rise && !sat && cnt_q >= MIN_C) begin
      bit_valid = 1'b1;
      bit_val   = (cnt_q < SPLIT_C);
      cnt_d     = ONE_C;
    end else if (rise && sat) begin
      cnt_d = ONE_C;
    end else if (cnt_q == MAX_C - ONE_C) begin
      gap = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= MAX_C;
    end else begin
      sync1_q <= cout;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/cassette_rec.sv
// MC-10 tape recorder: FSK cassette-out decoded to bytes, streamed with a
// linear buffer address over a valid/ready handshake.
module cassette_rec
  import cassette_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 14_318_180,
  parameter int unsigned T_MIN   = CLK_HZ / 3600,
  parameter int unsigned T_SPLIT = CLK_HZ / 1800,
  parameter int unsigned T_MAX   = CLK_HZ / 600
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              cout,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              locked,
  output logic              overflow
);

  logic bit_valid, bit_val, gap;

  cassette_period #(
    .T_MIN  (T_MIN),
    .T_SPLIT(T_SPLIT),
    .T_MAX  (T_MAX)
  ) u_period (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .enable   (enable),
    .cout     (cout),
    .bit_valid(bit_valid),
    .bit_val  (bit_val),
    .gap      (gap)
  );

  rec_state_t        state_q, state_d;
  logic [7:0]        sr_q, sr_d, sr_next;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              overflow_q, overflow_d;
  logic              present;

  assign sr_next = {bit_val, sr_q[7:1]};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bitcnt_d    = bitcnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    overflow_d  = overflow_q;
    present     = 1'b0;

    if (!enable || gap) begin
      state_d  = HUNT;
      sr_d     = '0;
      bitcnt_d = '0;
    end else if (bit_valid) begin
      sr_d = sr_next;
      if (state_q == HUNT) begin
        if (sr_next == SYNC_BYTE) begin
          present  = 1'b1;
          bitcnt_d = '0;
          state_d  = DATA;
        end
      end else if (bitcnt_q == 3'd7) begin
        present  = 1'b1;
        bitcnt_d = '0;
      end else begin
        bitcnt_d = bitcnt_q + 3'd1;
      end
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_addr_d  = out_addr_q + ADDR_W'(1);
    end

    // A byte completing while the previous one is still held is dropped.
    if (present) begin
      if (!out_valid_q) begin
        out_data_d  = sr_next;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (clear) begin
      out_addr_d = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bitcnt_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bitcnt_q    <= bitcnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign overflow  = overflow_q;
  assign locked    = (state_q == DATA);

endmodule

// File: tb/tb_cassette_rec.sv
// Scoreboard bench for cassette_rec: bit-stream reference model feeds an
// expected-byte queue that a negedge monitor drains on each accept.
module tb_cassette_rec;
  import cassette_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        cout = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [24:0] out_addr;
  logic        locked;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  cassette_rec #(.CLK_HZ(36000)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .enable   (enable),
    .clear    (clear),
    .cout     (cout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .locked   (locked),
    .overflow (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model state
  bit          hw[$];
  bit          dq[$];
  bit          m_locked;
  logic [24:0] exp_addr;
  logic [7:0]  exp_d[$];
  logic [24:0] exp_a[$];
  logic [7:0]  held[$];
  bit          push_en = 1'b1;
  bit          lock_chk = 1'b1;
  logic [7:0]  ed;
  logic [24:0] ea;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] qval(input bit q[$]);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = q[i];
    return v;
  endfunction

  task automatic emit(input logic [7:0] v);
    if (push_en) begin
      exp_d.push_back(v);
      exp_a.push_back(exp_addr);
      exp_addr = exp_addr + 25'd1;
    end else begin
      held.push_back(v);
    end
  endtask

  task automatic model_hunt();
    m_locked = 1'b0;
    hw.delete();
    repeat (8) hw.push_back(1'b0);
    dq.delete();
  endtask

  task automatic model_reset();
    model_hunt();
    exp_addr = '0;
  endtask

  task automatic model_bit(input bit b);
    if (!m_locked) begin
      hw.push_back(b);
      void'(hw.pop_front());
      if (qval(hw) == SYNC_BYTE) begin
        emit(SYNC_BYTE);
        m_locked = 1'b1;
        dq.delete();
      end
    end else begin
      dq.push_back(b);
      if (dq.size() == 8) begin
        emit(qval(dq));
        dq.delete();
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // One FSK cycle per bit; optional glitch pulse lands early in a 0-bit.
  task automatic send_bit(input bit b, input bit glitch);
    if (!b && glitch) begin
      cout = 1'b1; tick(3);
      cout = 1'b0; tick(2);
      cout = 1'b1; tick(4);
      cout = 1'b0; tick(21);
    end else begin
      cout = 1'b1; tick(b ? 7 : 15);
      cout = 1'b0; tick(b ? 8 : 15);
    end
    if (enable) model_bit(b);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gmode);
    for (int i = 0; i < 8; i++)
      send_bit(v[i], (gmode == 1) || (gmode == 2 && $urandom_range(0, 1) == 1));
  endtask

  task automatic end_stream();
    cout = 1'b1; tick(5);
    cout = 1'b0; tick(80);
    model_hunt();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    model_reset();
  endtask

  always @(negedge clk_sys) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_d.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got data %0h addr %0d, none expected", out_data, out_addr);
      end else begin
        ed = exp_d.pop_front();
        ea = exp_a.pop_front();
        chk("out_data", out_data, ed);
        chk("out_addr", out_addr, ea);
        if (lock_chk) chk("locked_with_byte", locked, 1);
      end
    end
  end

  initial begin
    model_reset();
    reset_n = 1'b0;
    tick(3);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_locked", locked, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    tick(2);

    // Leader then sync then one data byte
    repeat (4) send_byte(LEADER_BYTE, 0);
    chk("locked_in_leader", locked, 0);
    send_byte(SYNC_BYTE, 0);
    send_byte(8'hA7, 0);
    end_stream();
    chk("leader_drained", exp_d.size(), 0);

    // Glitch pulses inside every 0-bit
    send_byte(SYNC_BYTE, 1);
    send_byte(8'h00, 1);
    end_stream();
    chk("glitch_drained", exp_d.size(), 0);

    // Gap mid-byte drops partial data and unlocks
    send_byte(SYNC_BYTE, 0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("locked_before_gap", locked, 1);
    cout = 1'b0;
    tick(70);
    model_hunt();
    chk("locked_after_gap", locked, 0);
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h11, 0);
    end_stream();
    chk("gap_drained", exp_d.size(), 0);

    // Disarmed recorder ignores the stream
    enable = 1'b0;
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h99, 0);
    end_stream();
    chk("disabled_locked", locked, 0);
    enable = 1'b1;
    chk("disabled_drained", exp_d.size(), 0);

    // Randomized frames with random glitches
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(1, 3)) send_byte(LEADER_BYTE, 0);
      send_byte(SYNC_BYTE, 0);
      repeat ($urandom_range(2, 5)) send_byte(8'($urandom), 2);
      end_stream();
      chk("random_drained", exp_d.size(), 0);
    end

    // Backpressure: first byte held, later ones dropped
    do_reset();
    out_ready = 1'b0;
    push_en = 1'b0;
    lock_chk = 1'b0;
    held.delete();
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    end_stream();
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, held[0]);
    chk("bp_overflow", overflow, (held.size() > 1) ? 1 : 0);
    chk("bp_addr", out_addr, 0);
    push_en = 1'b1;
    emit(held[0]);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("bp_addr_after", out_addr, exp_addr);
    chk("bp_valid_after", out_valid, 0);
    chk("bp_drained", exp_d.size(), 0);

    // Advance address to 5, then clear on the same clock as an accept
    out_ready = 1'b1;
    lock_chk = 1'b1;
    send_byte(SYNC_BYTE, 0);
    repeat (3) send_byte(8'($urandom), 0);
    end_stream();
    chk("fill_drained", exp_d.size(), 0);
    chk("addr_before_clear", out_addr, exp_addr);
    out_ready = 1'b0;
    push_en = 1'b0;
    lock_chk = 1'b0;
    held.delete();
    send_byte(SYNC_BYTE, 0);
    end_stream();
    chk("clr_pre_valid", out_valid, 1);
    chk("clr_pre_overflow", overflow, 1);
    push_en = 1'b1;
    emit(held[0]);
    out_ready = 1'b1;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    out_ready = 1'b0;
    exp_addr = '0;
    chk("clr_addr", out_addr, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_valid", out_valid, 0);

    // Asynchronous reset during the 4th data bit
    out_ready = 1'b1;
    lock_chk = 1'b1;
    send_byte(SYNC_BYTE, 0);
    repeat (3) send_bit(1'($urandom), 1'b0);
    chk("pre_reset_locked", locked, 1);
    cout = 1'b1;
    tick(5);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_out_data", out_data, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_addr", out_addr, 0);
    chk("arst_locked", locked, 0);
    chk("arst_overflow", overflow, 0);
    model_reset();
    cout = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    send_byte(SYNC_BYTE, 0);
    send_byte(8'h5A, 0);
    end_stream();
    chk("arst_drained", exp_d.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
